ddr3_wb_adapter: RTL and testbench
==================================

DDR3_WB_ADAPTER -- requirements
Module: ddr3_wb_adapter

Interface
REQ-001 Parameter ADDR_WIDTH, default 28: width of the controller word address outputs.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_wbs_cyc, i_wbs_stb, i_wbs_we  in  1 each  Wishbone classic slave cycle, strobe and write-enable.
REQ-005 i_wbs_adr  in  32  word address; bits [ADDR_WIDTH-1:0] are used.
REQ-006 i_wbs_dat  in  32  write data.
REQ-007 o_wbs_dat  out  32  read data.
REQ-008 o_wbs_ack  out  1  one-cycle beat acknowledge.
REQ-009 write_address, read_address  out  ADDR_WIDTH  start addresses driven to the DDR3 controller.
REQ-010 write_en, read_en  out  1  transaction enables driven to the DDR3 controller.
REQ-011 if_write_ready  in  2, if_write_activate  out  2, if_write_fifo_size  in  24, if_write_strobe  out  1, if_write_data  out  32, if_starved  in  1  ping-pong FIFO write side.
REQ-012 of_read_ready  in  1, of_read_activate  out  1, of_read_size  in  24, of_read_strobe  out  1, of_read_data  in  32  ping-pong FIFO read side.

Function
REQ-013 The block SHALL use FSM states IDLE, WR_WAIT, WR_STREAM, WR_FLUSH, RD_WAIT, RD_STREAM, RD_ACK.
REQ-014 IDLE: on i_wbs_cyc&i_wbs_stb&i_wbs_we, the block SHALL latch write_address from i_wbs_adr, assert write_en, and go to WR_WAIT.
REQ-015 IDLE: on i_wbs_cyc&i_wbs_stb&!i_wbs_we, the block SHALL latch read_address, assert read_en, and go to RD_WAIT.
REQ-016 WR_WAIT: with if_write_activate==0 and if_write_ready!=0, it SHALL activate bit 0 when ready[0] is set, otherwise bit 1, clear the 24-bit beat counter, and go to WR_STREAM.
REQ-017 WR_STREAM: on each cycle with cyc&stb&we, !o_wbs_ack and count<if_write_fifo_size, it SHALL register if_write_data=i_wbs_dat, pulse if_write_strobe and o_wbs_ack for one cycle, and increment the counter.
REQ-018 When the counter reaches if_write_fifo_size, it SHALL clear if_write_activate in the next cycle and return to WR_WAIT; stb remains un-acked until a new half is active.
REQ-019 When i_wbs_cyc falls in WR_WAIT/WR_STREAM, it SHALL release an active half holding count>0 (a half with count 0 is released without strobes) and go to WR_FLUSH.
REQ-020 WR_FLUSH: it SHALL hold write_en high until if_starved is sampled high with if_write_activate==0, then deassert write_en and return to IDLE.
REQ-021 RD_WAIT: when of_read_ready&!of_read_activate, it SHALL assert of_read_activate, clear the counter, and go to RD_STREAM.
REQ-022 RD_STREAM: on cyc&stb&!we with count<of_read_size, it SHALL latch o_wbs_dat=of_read_data, pulse of_read_strobe, increment the counter, and go to RD_ACK.
REQ-023 RD_ACK: it SHALL pulse o_wbs_ack for one cycle and return to RD_STREAM; ack latency is 2 cycles after stb is sampled with an active half.
REQ-024 When count==of_read_size, it SHALL drop of_read_activate and return to RD_WAIT.
REQ-025 When i_wbs_cyc falls in any RD_* state, it SHALL deassert read_en and of_read_activate within one cycle and return to IDLE; residual FIFO data is discarded by the controller.
REQ-026 A cyc change of i_wbs_we mid-transaction SHALL be ignored until return to IDLE.
REQ-027 o_wbs_ack SHALL never assert on two consecutive cycles, and SHALL never assert without cyc&stb in the prior cycle.
REQ-028 Address outputs SHALL hold their latched value until the next IDLE capture.

Reset
REQ-029 On rst the block SHALL enter IDLE with all outputs 0: write_en, read_en, addresses, activates, strobes, o_wbs_ack, o_wbs_dat, if_write_data, counters.
REQ-030 rst mid-transaction SHALL take effect on the next clk edge, with no further ack or strobe.

Verification
REQ-031 Write 4 beats at adr 0x100, fifo_size 64, ready=2'b11 -> write_address=0x100, activate=2'b01, 4 strobes/acks, release on cyc drop, write_en low after if_starved.
REQ-032 Write 70 beats, size 64 -> half 0 filled with 64, released, half 1 activated, 6 more beats, then flush.
REQ-033 Read 3 beats at 0x200, of_read_ready after 10 cycles -> read_en high, read_address=0x200, each ack 2 cycles after stb, data matches of_read_data.
REQ-034 Read with cyc dropped after 1 of 8 beats -> read_en and of_read_activate low next cycle, state IDLE.
REQ-035 Write with if_write_ready=0 for 20 cycles -> no ack, no strobe; ack follows ready.
REQ-036 rst asserted during WR_STREAM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ddr3_wb_adapter.sv
// Wishbone classic slave bridging single-beat bursts onto a DDR3 controller's
// ping-pong write FIFO and read FIFO, with start-address/enable handshake.
module ddr3_wb_adapter #(
    parameter int ADDR_WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wbs_cyc,
    input  logic                  i_wbs_stb,
    input  logic                  i_wbs_we,
    input  logic [31:0]           i_wbs_adr,
    input  logic [31:0]           i_wbs_dat,
    output logic [31:0]           o_wbs_dat,
    output logic                  o_wbs_ack,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic                  write_en,
    output logic                  read_en,
    input  logic [1:0]            if_write_ready,
    output logic [1:0]            if_write_activate,
    input  logic [23:0]           if_write_fifo_size,
    output logic                  if_write_strobe,
    output logic [31:0]           if_write_data,
    input  logic                  if_starved,
    input  logic                  of_read_ready,
    output logic                  of_read_activate,
    input  logic [23:0]           of_read_size,
    output logic                  of_read_strobe,
    input  logic [31:0]           of_read_data
);

    typedef enum logic [2:0] {
        IDLE, WR_WAIT, WR_STREAM, WR_FLUSH, RD_WAIT, RD_STREAM, RD_ACK
    } state_t;

    state_t                  state, state_next;
    logic [23:0]             count, count_next;
    logic                    write_en_next, read_en_next, ack_next;
    logic                    wr_strobe_next, rd_strobe_next, rd_act_next;
    logic [1:0]              wr_act_next;
    logic [ADDR_WIDTH-1:0]   wr_addr_next, rd_addr_next;
    logic [31:0]             wr_data_next, rd_data_next;

    // Upper address bits are intentionally ignored.
    logic unused_adr;
    assign unused_adr = ^i_wbs_adr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            count             <= '0;
            write_en          <= 1'b0;
            read_en           <= 1'b0;
            write_address     <= '0;
            read_address      <= '0;
            if_write_activate <= 2'b00;
            if_write_strobe   <= 1'b0;
            if_write_data     <= '0;
            of_read_activate  <= 1'b0;
            of_read_strobe    <= 1'b0;
            o_wbs_ack         <= 1'b0;
            o_wbs_dat         <= '0;
        end else begin
            state             <= state_next;
            count             <= count_next;
            write_en          <= write_en_next;
            read_en           <= read_en_next;
            write_address     <= wr_addr_next;
            read_address      <= rd_addr_next;
            if_write_activate <= wr_act_next;
            if_write_strobe   <= wr_strobe_next;
            if_write_data     <= wr_data_next;
            of_read_activate  <= rd_act_next;
            of_read_strobe    <= rd_strobe_next;
            o_wbs_ack         <= ack_next;
            o_wbs_dat         <= rd_data_next;
        end
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        write_en_next  = write_en;
        read_en_next   = read_en;
        wr_addr_next   = write_address;
        rd_addr_next   = read_address;
        wr_act_next    = if_write_activate;
        wr_strobe_next = 1'b0;
        wr_data_next   = if_write_data;
        rd_act_next    = of_read_activate;
        rd_strobe_next = 1'b0;
        ack_next       = 1'b0;
        rd_data_next   = o_wbs_dat;

        case (state)
            IDLE: begin
                if (i_wbs_cyc && i_wbs_stb) begin
                    if (i_wbs_we) begin
                        wr_addr_next  = i_wbs_adr[ADDR_WIDTH-1:0];
                        write_en_next = 1'b1;
                        state_next    = WR_WAIT;
                    end else begin
                        rd_addr_next  = i_wbs_adr[ADDR_WIDTH-1:0];
                        read_en_next  = 1'b1;
                        state_next    = RD_WAIT;
                    end
                end
            end
            WR_WAIT: begin
                if (!i_wbs_cyc) begin
                    wr_act_next = 2'b00;
                    state_next  = WR_FLUSH;
                end else if (if_write_activate == 2'b00 && if_write_ready != 2'b00) begin
                    wr_act_next = if_write_ready[0] ? 2'b01 : 2'b10;
                    count_next  = '0;
                    state_next  = WR_STREAM;
                end
            end
            WR_STREAM: begin
                // Losing cyc wins over everything: hand the partial half to the controller.
                if (!i_wbs_cyc) begin
                    wr_act_next = 2'b00;
                    state_next  = WR_FLUSH;
                end else if (count >= if_write_fifo_size) begin
                    wr_act_next = 2'b00;
                    state_next  = WR_WAIT;
                end else if (i_wbs_stb && i_wbs_we && !o_wbs_ack) begin
                    wr_data_next   = i_wbs_dat;
                    wr_strobe_next = 1'b1;
                    ack_next       = 1'b1;
                    count_next     = count + 24'd1;
                end
            end
            WR_FLUSH: begin
                if (if_starved && if_write_activate == 2'b00) begin
                    write_en_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            RD_WAIT: begin
                if (!i_wbs_cyc) begin
                    read_en_next = 1'b0;
                    rd_act_next  = 1'b0;
                    state_next   = IDLE;
                end else if (of_read_ready && !of_read_activate) begin
                    rd_act_next = 1'b1;
                    count_next  = '0;
                    state_next  = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (!i_wbs_cyc) begin
                    read_en_next = 1'b0;
                    rd_act_next  = 1'b0;
                    state_next   = IDLE;
                end else if (count >= of_read_size) begin
                    rd_act_next = 1'b0;
                    state_next  = RD_WAIT;
                end else if (i_wbs_stb && !i_wbs_we) begin
                    rd_data_next   = of_read_data;
                    rd_strobe_next = 1'b1;
                    count_next     = count + 24'd1;
                    state_next     = RD_ACK;
                end
            end
            RD_ACK: begin
                if (!i_wbs_cyc) begin
                    read_en_next = 1'b0;
                    rd_act_next  = 1'b0;
                    state_next   = IDLE;
                end else begin
                    ack_next   = 1'b1;
                    state_next = RD_STREAM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr3_wb_adapter.sv
// Randomized bench for ddr3_wb_adapter: Wishbone master tasks plus behavioural
// ping-pong write FIFO and read FIFO models that the expectations are derived from.
module tb_ddr3_wb_adapter;

    localparam int AW    = 28;
    localparam int TMO   = 1000;
    localparam int DRAIN = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_wbs_cyc = 1'b0, i_wbs_stb = 1'b0, i_wbs_we = 1'b0;
    logic [31:0]   i_wbs_adr = '0, i_wbs_dat = '0;
    logic [31:0]   o_wbs_dat;
    logic          o_wbs_ack;
    logic [AW-1:0] write_address, read_address;
    logic          write_en, read_en;
    logic [1:0]    if_write_ready, if_write_activate;
    logic [23:0]   wr_size = 24'd64, rd_size = 24'd8;
    logic          if_write_strobe, if_starved;
    logic [31:0]   if_write_data;
    logic          of_read_ready, of_read_activate, of_read_strobe;
    logic [31:0]   of_read_data;

    int total = 0, bad = 0;

    // Stimulus-side knobs (written by the main sequence only)
    logic        wr_block = 1'b0;
    logic        rd_hold  = 1'b0;
    logic [31:0] rd_mem [64];

    // Model state (written by the FIFO monitor only)
    int          drain [2] = '{0, 0};
    int          cur_fill = 0, rd_ptr = 0, rd_delay = 0;
    int          str_cnt = 0, ack_cnt = 0, viol = 0;
    logic        prev_ack = 1'b0, prev_cs = 1'b0, prev_ract = 1'b0;
    logic [1:0]  prev_act = 2'b00;
    int          fill_q[$], half_q[$];
    logic [31:0] wr_got_q[$];

    // Per-transaction records from the master
    int          lat_q[$];
    logic [31:0] rd_got_q[$], wr_exp_q[$];

    always #5 clk = ~clk;

    assign if_write_ready = {!wr_block && drain[1] == 0, !wr_block && drain[0] == 0};
    assign if_starved     = (drain[0] == 0) && (drain[1] == 0) && (if_write_activate == 2'b00);
    assign of_read_ready  = !rd_hold && (rd_delay == 0);
    assign of_read_data   = rd_mem[rd_ptr[5:0]];

    ddr3_wb_adapter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_wbs_cyc(i_wbs_cyc), .i_wbs_stb(i_wbs_stb), .i_wbs_we(i_wbs_we),
        .i_wbs_adr(i_wbs_adr), .i_wbs_dat(i_wbs_dat),
        .o_wbs_dat(o_wbs_dat), .o_wbs_ack(o_wbs_ack),
        .write_address(write_address), .read_address(read_address),
        .write_en(write_en), .read_en(read_en),
        .if_write_ready(if_write_ready), .if_write_activate(if_write_activate),
        .if_write_fifo_size(wr_size), .if_write_strobe(if_write_strobe),
        .if_write_data(if_write_data), .if_starved(if_starved),
        .of_read_ready(of_read_ready), .of_read_activate(of_read_activate),
        .of_read_size(rd_size), .of_read_strobe(of_read_strobe),
        .of_read_data(of_read_data)
    );

    // FIFO behaviour and Wishbone protocol watch, sampled mid-cycle
    always @(negedge clk) begin
        if (if_write_strobe) begin
            wr_got_q.push_back(if_write_data);
            cur_fill++;
            str_cnt++;
        end
        for (int h = 0; h < 2; h++) begin
            if (prev_act[h] && !if_write_activate[h]) begin
                if (cur_fill > 0) begin
                    fill_q.push_back(cur_fill);
                    half_q.push_back(h);
                    drain[h] = DRAIN;
                end
                cur_fill = 0;
            end else if (drain[h] > 0) begin
                drain[h]--;
            end
        end
        prev_act = if_write_activate;
        if (of_read_strobe) rd_ptr++;
        if (prev_ract && !of_read_activate) rd_delay = 3;
        else if (rd_delay > 0) rd_delay--;
        prev_ract = of_read_activate;
        if (o_wbs_ack) begin
            ack_cnt++;
            if (prev_ack || !prev_cs) viol++;
        end
        prev_ack = o_wbs_ack;
        prev_cs  = i_wbs_cyc && i_wbs_stb;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input int n);
        int lat;
        lat_q.delete();
        rd_got_q.delete();
        wr_exp_q.delete();
        i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = we;
        i_wbs_adr = adr;  i_wbs_dat = $urandom;
        if (we) wr_exp_q.push_back(i_wbs_dat);
        @(posedge clk); #1;
        if (we) begin
            chk("wr_en_rise", write_en, 1);
            chk("wr_addr", write_address, adr[AW-1:0]);
        end else begin
            chk("rd_en_rise", read_en, 1);
            chk("rd_addr", read_address, adr[AW-1:0]);
        end
        for (int b = 0; b < n; b++) begin
            if (b > 0) begin
                i_wbs_dat = $urandom;
                if (we) wr_exp_q.push_back(i_wbs_dat);
            end
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!o_wbs_ack && lat < TMO);
            if (!o_wbs_ack) begin
                chk("ack_timeout", o_wbs_ack, 1);
                break;
            end
            lat_q.push_back(lat);
            if (!we) rd_got_q.push_back(o_wbs_dat);
        end
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0; i_wbs_we = 1'b0;
    endtask

    task automatic wr_txn(input logic [31:0] adr, input int n, input int size);
        int fb, wb, k, rem, chunk;
        wr_size = size[23:0];
        fb = fill_q.size();
        wb = wr_got_q.size();
        wb_xfer(1'b1, adr, n);
        @(posedge clk); #1;
        chk("wr_flush_hold", write_en, 1);
        k = 0;
        while (write_en && k < TMO) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wr_flush_done", write_en, 0);
        chk("wr_act_idle", if_write_activate, 0);
        chk("wr_strobes", wr_got_q.size() - wb, n);
        for (int i = 0; i < n && i < wr_exp_q.size() && wb + i < wr_got_q.size(); i++)
            chk("wr_data", wr_got_q[wb + i], wr_exp_q[i]);
        rem = n;
        k   = fb;
        while (rem > 0) begin
            chunk = (rem < size) ? rem : size;
            chk("wr_fill", (k < fill_q.size()) ? fill_q[k] : 0, chunk);
            rem -= chunk;
            k++;
        end
        chk("wr_halves", fill_q.size() - fb, k - fb);
    endtask

    task automatic rd_txn(input logic [31:0] adr, input int n, input int size, input int hold);
        int rs;
        rs      = rd_ptr;
        rd_size = size[23:0];
        rd_hold = 1'b1;
        fork
            begin
                repeat (hold) @(posedge clk);
                rd_hold = 1'b0;
            end
            wb_xfer(1'b0, adr, n);
        join
        @(posedge clk); #1;
        chk("rd_en_drop", read_en, 0);
        chk("rd_act_drop", of_read_activate, 0);
        chk("rd_beats", rd_got_q.size(), n);
        for (int i = 0; i < rd_got_q.size(); i++)
            chk("rd_data", rd_got_q[i], rd_mem[(rs + i) % 64]);
        for (int i = 1; i < lat_q.size(); i++)
            if (i % size != 0) chk("rd_ack_lat", lat_q[i], 2);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int fb, k, s0, a0;
        for (int i = 0; i < 64; i++) rd_mem[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {write_en, read_en, if_write_activate, if_write_strobe,
                         of_read_activate, of_read_strobe, o_wbs_ack, write_address}, 0);
        chk("rst_raddr", read_address, 0);
        chk("rst_data", {if_write_data, o_wbs_dat}, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Short write burst into half 0
        fb = half_q.size();
        wr_txn(32'h100, 4, 64);
        chk("wr4_half", (half_q.size() > fb) ? half_q[fb] : 9, 0);
        repeat (10) @(posedge clk);

        // Burst larger than one half: half 0 full, then half 1
        fb = half_q.size();
        wr_txn(32'h0000_0080, 70, 64);
        chk("wr70_half0", (half_q.size() > fb) ? half_q[fb] : 9, 0);
        chk("wr70_half1", (half_q.size() > fb + 1) ? half_q[fb + 1] : 9, 1);
        repeat (10) @(posedge clk);

        // Read with the FIFO becoming ready late
        rd_txn(32'h200, 3, 8, 10);
        repeat (5) @(posedge clk);

        // Read abandoned after one of eight beats
        rd_txn(32'h0abc_0040, 1, 8, 2);
        repeat (5) @(posedge clk);

        // Write with no ready half for 20 cycles
        wr_block = 1'b1;
        s0 = str_cnt;
        a0 = ack_cnt;
        fork
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("blk_no_strobe", str_cnt - s0, 0);
                chk("blk_no_ack", ack_cnt - a0, 0);
                wr_block = 1'b0;
            end
            wr_txn(32'h400, 3, 16);
        join
        repeat (10) @(posedge clk);

        // Reset in the middle of a write stream
        wr_size   = 24'd64;
        i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = 1'b1;
        i_wbs_adr = 32'h300; i_wbs_dat = $urandom;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!o_wbs_ack && k < TMO);
        chk("rst_pre_ack", o_wbs_ack, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ctrl", {write_en, read_en, if_write_activate, if_write_strobe,
                             of_read_activate, of_read_strobe, o_wbs_ack, write_address}, 0);
        chk("rst_mid_data", {if_write_data, o_wbs_dat}, 0);
        @(posedge clk); #1;
        chk("rst_mid_quiet", {o_wbs_ack, if_write_strobe}, 0);
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0; i_wbs_we = 1'b0;
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Randomized mix
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1)
                wr_txn($urandom, $urandom_range(1, 24), $urandom_range(3, 12));
            else
                rd_txn($urandom, $urandom_range(1, 10), $urandom_range(2, 6), $urandom_range(0, 5));
            repeat (10) @(posedge clk);
        end

        chk("ack_protocol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
